mmio_arbiter: RTL and testbench
===============================

# mmio_arbiter

Shares one MMIO register block among NUM_REQ requesters, such as the host MMIO path, the DMA controller's internal configuration path and a debug port. It grants one requester per cycle using round-robin. It drives the register block through registered read and write channels, using the same signal set as the block's user-side MMIO interface. Read data returns to the owning requester after a fixed latency, with a per-requester valid strobe.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 64, MMIO data width.
- ADDR_WIDTH, 16, MMIO address width.
- READ_LATENCY, 1, cycles from mmio_rd_en to valid mmio_rd_data in the register block (0..4).
- START_ADDR, 0, lowest legal address (used only when range checking is compiled in).
- END_ADDR, 2**ADDR_WIDTH-1, highest legal address (used only when range checking is compiled in).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_rd_en  in  NUM_REQ  per-requester read request.
- req_wr_en  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wr_data  in  NUM_REQ*DATA_WIDTH  flattened write data.
- req_gnt  out  NUM_REQ  one-hot grant, combinational.
- req_rd_data  out  DATA_WIDTH  read data, broadcast to all requesters.
- req_rd_valid  out  NUM_REQ  one-hot; read data belongs to requester i.
- mmio_rd_en / mmio_rd_addr  out  1 / ADDR_WIDTH  read channel to the register block.
- mmio_wr_en / mmio_wr_addr / mmio_wr_data  out  1 / ADDR_WIDTH / DATA_WIDTH  write channel to the register block.
- mmio_rd_data  in  DATA_WIDTH  read data from the register block.
- range_err  out  1  sticky error flag (range-check builds only; tied 0 otherwise).

## Operation
- A requester is active when req_rd_en[i] or req_wr_en[i] is high.
- A requester holds its enables, address and data stable until it sees req_gnt[i]=1.
- An access completes in the grant cycle. The requester deasserts, or presents a new access, in the next cycle.
- Arbitration is round-robin. Priority starts at (last_grant+1) mod NUM_REQ and searches upward with wrap-around.
- last_grant resets to NUM_REQ-1, so requester 0 has highest priority after reset.
- last_grant updates only in cycles where a grant is issued.
- At most one requester is granted per cycle.
- If the granted requester asserts both rd_en and wr_en, both are issued in the same cycle on their separate channels. The read sees the register block's pre-write value, because that block reads before it writes.
- Owner tracking uses a tag shift pipeline of depth READ_LATENCY+1.
  - Each stage holds a valid bit and the owner index.
  - The stage that aligns with mmio_rd_data drives req_rd_valid and req_rd_data.
- There is no backpressure on read return. Each requester must accept req_rd_valid in any cycle.
- Reset mid-operation:
  - All in-flight reads are discarded; no req_rd_valid is produced for them.
  - mmio_*_en deassert immediately, because the reset is asynchronous.

## Timing
- Reset values:
  - req_gnt, because no request is active.
  - req_rd_valid = 0 and req_rd_data = 0.
  - mmio_rd_en = mmio_wr_en = 0.
  - mmio_rd_addr, mmio_wr_addr and mmio_wr_data = 0.
  - range_err = 0.
  - All tag-pipeline valid bits = 0.
- Grant in cycle N: the mmio_* channel signals are registered and valid in cycle N+1.
- Read granted in cycle N: req_rd_valid[i] pulses for one cycle at N+1+READ_LATENCY.
- req_rd_data equals mmio_rd_data in that cycle, passed through combinationally from the aligned stage.
- Throughput is one access per cycle. Back-to-back reads from different requesters return in grant order, one per cycle.
- mmio_rd_en and mmio_wr_en are single-cycle pulses per grant. Address and data hold their last value when the enable is low.

## Configuration
- MMIO_ARBITER_RANGE_CHECK_EN defined:
  - A granted access with addr < START_ADDR or addr > END_ADDR is not forwarded; the mmio_* enables stay 0.
  - A rejected read still produces req_rd_valid at the normal latency, with req_rd_data = 0.
  - Any rejected access sets range_err. range_err clears only on reset.
- MMIO_ARBITER_RANGE_CHECK_EN undefined:
  - All accesses are forwarded unchanged.
  - START_ADDR and END_ADDR are ignored and range_err is tied to 0.

## Test plan
- Reset release:
  - With no requests: all outputs are 0 for 10 cycles.
  - Assert rst_n=0 with two reads in flight (READ_LATENCY=2), then release: no req_rd_valid appears.
- Single read, READ_LATENCY=1: req 2 reads 0x0010 in cycle 5.
  - req_gnt=4'b0100 in cycle 5.
  - mmio_rd_en=1 with mmio_rd_addr=0x0010 in cycle 6.
  - req_rd_valid=4'b0100 with the model's data in cycle 7.
- Round-robin fairness: all 4 requesters hold reads continuously for 8 cycles.
  - Grants are 0,1,2,3,0,1,2,3.
  - Read returns arrive in the same order, one per cycle.
- Simultaneous read and write from req 1: addr 0x20, write data 0xDEAD, old register value 0xBEEF.
  - Both channels pulse in the same cycle.
  - req_rd_data = 0xBEEF.
  - A subsequent read returns 0xDEAD.
- Idle-gap priority: grant req 3, idle 3 cycles, then req 0 and req 3 request together.
  - req 0 is granted first.
- Range check (macro defined, START_ADDR=0x100, END_ADDR=0x1FF):
  - A read of 0x080 gives no mmio_rd_en, req_rd_valid at the normal latency with data 0, and range_err=1.
  - A read of 0x100 is forwarded normally and range_err stays 1.

Source files
------------

// File: rtl/mmio_arbiter.sv
// Round-robin arbiter that shares one MMIO register block among NUM_REQ requesters.
// Optional address range checking is compiled in with MMIO_ARBITER_RANGE_CHECK_EN.
module mmio_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = {ADDR_WIDTH{1'b0}},
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = {ADDR_WIDTH{1'b1}}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_rd_en,
  input  logic [NUM_REQ-1:0]            req_wr_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [DATA_WIDTH-1:0]         req_rd_data,
  output logic [NUM_REQ-1:0]            req_rd_valid,
  output logic                          mmio_rd_en,
  output logic [ADDR_WIDTH-1:0]         mmio_rd_addr,
  output logic                          mmio_wr_en,
  output logic [ADDR_WIDTH-1:0]         mmio_wr_addr,
  output logic [DATA_WIDTH-1:0]         mmio_wr_data,
  input  logic [DATA_WIDTH-1:0]         mmio_rd_data,
  output logic                          range_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RL    = READ_LATENCY;

  logic [NUM_REQ-1:0]    active_s;
  logic [IDX_W-1:0]      last_grant_r;
  logic [IDX_W-1:0]      cand_s;
  logic [IDX_W-1:0]      gnt_idx_s;
  logic                  found_s;
  logic [NUM_REQ-1:0]    gnt_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic                  sel_rd_s;
  logic                  sel_wr_s;
  logic                  in_range_s;

  logic                  mmio_rd_en_r;
  logic                  mmio_wr_en_r;
  logic [ADDR_WIDTH-1:0] mmio_rd_addr_r;
  logic [ADDR_WIDTH-1:0] mmio_wr_addr_r;
  logic [DATA_WIDTH-1:0] mmio_wr_data_r;

  logic [RL:0]           tag_vld_r;
  logic [RL:0]           tag_rej_r;
  logic [IDX_W-1:0]      tag_own_r [0:RL];

  assign active_s = req_rd_en | req_wr_en;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = {IDX_W{1'b0}};
    cand_s    = {IDX_W{1'b0}};
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_s    = IDX_W'((int'(last_grant_r) + off) % NUM_REQ);
      gnt_idx_s = (!found_s && active_s[cand_s]) ? cand_s : gnt_idx_s;
      found_s   = found_s | active_s[cand_s];
    end
    gnt_s = found_s ? (NUM_REQ'(1) << gnt_idx_s) : {NUM_REQ{1'b0}};
  end

  assign req_gnt     = gnt_s;
  assign sel_addr_s  = req_addr[int'(gnt_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata_s = req_wr_data[int'(gnt_idx_s)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_rd_s    = found_s & req_rd_en[gnt_idx_s];
  assign sel_wr_s    = found_s & req_wr_en[gnt_idx_s];

`ifdef MMIO_ARBITER_RANGE_CHECK_EN
  // Borrow bits of the two subtractions flag an address below START or above END
  logic                  lo_borrow_s;
  logic                  hi_borrow_s;
  logic [ADDR_WIDTH-1:0] unused_lo_diff_s;
  logic [ADDR_WIDTH-1:0] unused_hi_diff_s;
  logic                  range_err_r;

  assign {lo_borrow_s, unused_lo_diff_s} = {1'b0, sel_addr_s} - {1'b0, START_ADDR};
  assign {hi_borrow_s, unused_hi_diff_s} = {1'b0, END_ADDR} - {1'b0, sel_addr_s};
  assign in_range_s = ~lo_borrow_s & ~hi_borrow_s;

  // Sticky flag for any granted access that was dropped as out of range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err_r <= 1'b0;
    end else if (found_s && !in_range_s) begin
      range_err_r <= 1'b1;
    end
  end

  assign range_err = range_err_r;
`else
  logic unused_range_s;

  assign unused_range_s = ^{START_ADDR, END_ADDR};
  assign in_range_s     = 1'b1;
  assign range_err      = 1'b0;
`endif

  // Registered MMIO channels; address/data hold while the enable is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_rd_en_r   <= 1'b0;
      mmio_wr_en_r   <= 1'b0;
      mmio_rd_addr_r <= {ADDR_WIDTH{1'b0}};
      mmio_wr_addr_r <= {ADDR_WIDTH{1'b0}};
      mmio_wr_data_r <= {DATA_WIDTH{1'b0}};
      last_grant_r   <= IDX_W'(NUM_REQ - 1);
    end else begin
      mmio_rd_en_r <= sel_rd_s & in_range_s;
      mmio_wr_en_r <= sel_wr_s & in_range_s;
      if (sel_rd_s && in_range_s) begin
        mmio_rd_addr_r <= sel_addr_s;
      end
      if (sel_wr_s && in_range_s) begin
        mmio_wr_addr_r <= sel_addr_s;
        mmio_wr_data_r <= sel_wdata_s;
      end
      if (found_s) begin
        last_grant_r <= gnt_idx_s;
      end
    end
  end

  // Owner tag pipeline; stage RL lines up with mmio_rd_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_r <= {(RL+1){1'b0}};
      tag_rej_r <= {(RL+1){1'b0}};
      for (int k = 0; k <= RL; k++) begin
        tag_own_r[k] <= {IDX_W{1'b0}};
      end
    end else begin
      tag_vld_r[0] <= sel_rd_s;
      tag_rej_r[0] <= sel_rd_s & ~in_range_s;
      tag_own_r[0] <= gnt_idx_s;
      for (int k = 1; k <= RL; k++) begin
        tag_vld_r[k] <= tag_vld_r[k-1];
        tag_rej_r[k] <= tag_rej_r[k-1];
        tag_own_r[k] <= tag_own_r[k-1];
      end
    end
  end

  assign req_rd_valid = tag_vld_r[RL] ? (NUM_REQ'(1) << tag_own_r[RL]) : {NUM_REQ{1'b0}};
  assign req_rd_data  = (tag_vld_r[RL] && !tag_rej_r[RL]) ? mmio_rd_data : {DATA_WIDTH{1'b0}};

  assign mmio_rd_en   = mmio_rd_en_r;
  assign mmio_wr_en   = mmio_wr_en_r;
  assign mmio_rd_addr = mmio_rd_addr_r;
  assign mmio_wr_addr = mmio_wr_addr_r;
  assign mmio_wr_data = mmio_wr_data_r;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter: register-block model plus a read-return scoreboard.
// Define MMIO_ARBITER_RANGE_CHECK_EN to also exercise range checking.
module tb_mmio_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int AW = 16;
  localparam int RL = 1;
`ifdef MMIO_ARBITER_RANGE_CHECK_EN
  localparam logic [AW-1:0] OFS   = 16'h0100;
  localparam logic [AW-1:0] START = 16'h0100;
  localparam logic [AW-1:0] STOP  = 16'h01FF;
`else
  localparam logic [AW-1:0] OFS   = 16'h0000;
  localparam logic [AW-1:0] START = 16'h0000;
  localparam logic [AW-1:0] STOP  = 16'hFFFF;
`endif

  typedef struct {
    int          cyc;
    int          own;
    logic [DW-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_rd_en = '0;
  logic [NR-1:0]    req_wr_en = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wr_data = '0;
  logic [NR-1:0]    req_gnt;
  logic [DW-1:0]    req_rd_data;
  logic [NR-1:0]    req_rd_valid;
  logic             mmio_rd_en;
  logic [AW-1:0]    mmio_rd_addr;
  logic             mmio_wr_en;
  logic [AW-1:0]    mmio_wr_addr;
  logic [DW-1:0]    mmio_wr_data;
  logic [DW-1:0]    mmio_rd_data;
  logic             range_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [DW-1:0] blk_mem [0:511];
  logic          blk_wr  [0:511];
  logic [DW-1:0] ref_mem [0:511];
  logic          ref_wr  [0:511];
  logic [DW-1:0] blk_q = '0;

  mmio_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL),
    .START_ADDR(START), .END_ADDR(STOP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .req_gnt(req_gnt), .req_rd_data(req_rd_data), .req_rd_valid(req_rd_valid),
    .mmio_rd_en(mmio_rd_en), .mmio_rd_addr(mmio_rd_addr),
    .mmio_wr_en(mmio_wr_en), .mmio_wr_addr(mmio_wr_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data), .range_err(range_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == OFS + 16'h0020) ? 64'h0000_0000_0000_BEEF : {16'hC0DE, 32'h0000_0000, a};
  endfunction

  // Register block: read-before-write, one cycle read latency, junk when not reading
  always @(posedge clk) begin
    if (mmio_wr_en) begin
      blk_mem[mmio_wr_addr[8:0]] <= mmio_wr_data;
      blk_wr[mmio_wr_addr[8:0]]  <= 1'b1;
    end
    if (mmio_rd_en)
      blk_q <= (blk_wr[mmio_rd_addr[8:0]] === 1'b1) ? blk_mem[mmio_rd_addr[8:0]] : init_val(mmio_rd_addr);
    else
      blk_q <= 64'hFEED_FACE_CAFE_F00D;
  end
  assign mmio_rd_data = blk_q;

  // Scoreboard: each expected return is due in exactly one cycle
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (req_rd_valid !== (4'b0001 << mon_e.own) || req_rd_data !== mon_e.data) begin
        errors++;
        $display("FAIL rd_return cyc=%0d: got valid=%b data=%h, want valid=%b data=%h",
                 cyc, req_rd_valid, req_rd_data, 4'b0001 << mon_e.own, mon_e.data);
      end
    end else if (req_rd_valid !== 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rd_valid cyc=%0d: got valid=%b, want 0000", cyc, req_rd_valid);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic set_req(input int i, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rd_en[i] = r;
    req_wr_en[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wr_data[i*DW +: DW] = d;
  endtask

  task automatic idle_all();
    req_rd_en = '0;
    req_wr_en = '0;
  endtask

  task automatic push_exp(input int own, input logic [DW-1:0] d);
    exp_t e;
    e.cyc = cyc + 1 + RL;
    e.own = own;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic ref_read(input int own, input logic [AW-1:0] a);
    push_exp(own, (ref_wr[a[8:0]] === 1'b1) ? ref_mem[a[8:0]] : init_val(a));
  endtask

  task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ref_mem[a[8:0]] = d;
    ref_wr[a[8:0]]  = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    idle_all();
    sb.delete();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_gnt, req_rd_valid, req_rd_data, mmio_rd_en, mmio_wr_en, mmio_rd_addr,
         mmio_wr_addr, mmio_wr_data, range_err} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got nonzero outputs gnt=%b vld=%b, want all 0", req_gnt, req_rd_valid);
    end
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({req_gnt, req_rd_valid, req_rd_data, mmio_rd_en, mmio_wr_en, mmio_rd_addr,
           mmio_wr_addr, mmio_wr_data, range_err} !== '0) begin
        errors++;
        $display("FAIL reset_idle c=%0d: got gnt=%b rd_en=%b wr_en=%b, want all 0",
                 c, req_gnt, mmio_rd_en, mmio_wr_en);
      end
      next_cycle();
    end
  endtask

  task automatic test_single_read();
    logic [AW-1:0] a;
    a = OFS + 16'h0010;
    set_req(2, 1'b1, 1'b0, a, '0);
    @(negedge clk);
    checks++;
    if (req_gnt !== 4'b0100) begin
      errors++;
      $display("FAIL single_gnt: got %b, want 0100", req_gnt);
    end
    ref_read(2, a);
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++;
    if (mmio_rd_en !== 1'b1 || mmio_rd_addr !== a || mmio_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL single_mmio: got rd_en=%b addr=%h wr_en=%b, want 1 %h 0", mmio_rd_en, mmio_rd_addr, mmio_wr_en, a);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (mmio_rd_en !== 1'b0 || mmio_rd_addr !== a) begin
      errors++;
      $display("FAIL single_pulse: got rd_en=%b addr=%h, want 0 %h", mmio_rd_en, mmio_rd_addr, a);
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_round_robin();
    int cnt [NR];
    int exp_i;
    logic [AW-1:0] a;
    do_reset();
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NR; i++)
        set_req(i, 1'b1, 1'b0, OFS + 16'h0040 + AW'(i*8 + cnt[i]), '0);
      @(negedge clk);
      exp_i = c % NR;
      checks++;
      if (req_gnt !== (4'b0001 << exp_i)) begin
        errors++;
        $display("FAIL rr_gnt c=%0d: got %b, want %b", c, req_gnt, 4'b0001 << exp_i);
      end
      a = OFS + 16'h0040 + AW'(exp_i*8 + cnt[exp_i]);
      ref_read(exp_i, a);
      cnt[exp_i]++;
      next_cycle();
    end
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_rd_wr();
    logic [AW-1:0] a;
    a = OFS + 16'h0020;
    set_req(1, 1'b1, 1'b1, a, 64'h0000_0000_0000_DEAD);
    @(negedge clk);
    checks++;
    if (req_gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rw_gnt: got %b, want 0010", req_gnt);
    end
    ref_read(1, a);
    ref_write(a, 64'h0000_0000_0000_DEAD);
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++;
    if (mmio_rd_en !== 1'b1 || mmio_wr_en !== 1'b1 || mmio_rd_addr !== a ||
        mmio_wr_addr !== a || mmio_wr_data !== 64'h0000_0000_0000_DEAD) begin
      errors++;
      $display("FAIL rw_mmio: got rd_en=%b wr_en=%b ra=%h wa=%h wd=%h, want 1 1 %h %h DEAD",
               mmio_rd_en, mmio_wr_en, mmio_rd_addr, mmio_wr_addr, mmio_wr_data, a, a);
    end
    next_cycle();
    set_req(1, 1'b1, 1'b0, a, '0);
    @(negedge clk);
    checks++;
    if (req_gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rw_reread_gnt: got %b, want 0010", req_gnt);
    end
    ref_read(1, a);
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_idle_priority();
    set_req(3, 1'b1, 1'b0, OFS + 16'h0030, '0);
    @(negedge clk);
    checks++;
    if (req_gnt !== 4'b1000) begin
      errors++;
      $display("FAIL idle_first_gnt: got %b, want 1000", req_gnt);
    end
    ref_read(3, OFS + 16'h0030);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      idle_all();
      @(negedge clk);
      checks++;
      if (req_gnt !== 4'b0000) begin
        errors++;
        $display("FAIL idle_gap_gnt c=%0d: got %b, want 0000", c, req_gnt);
      end
    end
    next_cycle();
    set_req(0, 1'b1, 1'b0, OFS + 16'h0050, '0);
    set_req(3, 1'b1, 1'b0, OFS + 16'h0058, '0);
    @(negedge clk);
    checks++;
    if (req_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL idle_prio_gnt: got %b, want 0001", req_gnt);
    end
    ref_read(0, OFS + 16'h0050);
    next_cycle();
    set_req(0, 1'b0, 1'b0, OFS + 16'h0050, '0);
    @(negedge clk);
    checks++;
    if (req_gnt !== 4'b1000) begin
      errors++;
      $display("FAIL idle_second_gnt: got %b, want 1000", req_gnt);
    end
    ref_read(3, OFS + 16'h0058);
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_inflight();
    set_req(0, 1'b1, 1'b0, OFS + 16'h0060, '0);
    set_req(1, 1'b1, 1'b0, OFS + 16'h0068, '0);
    @(negedge clk);
    checks++;
    if (req_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL inflight_gnt0: got %b, want 0001", req_gnt);
    end
    next_cycle();
    set_req(0, 1'b0, 1'b0, OFS + 16'h0060, '0);
    @(negedge clk);
    checks++;
    if (req_gnt !== 4'b0010) begin
      errors++;
      $display("FAIL inflight_gnt1: got %b, want 0010", req_gnt);
    end
    next_cycle();
    idle_all();
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (mmio_rd_en !== 1'b0 || mmio_wr_en !== 1'b0 || req_rd_valid !== 4'b0000) begin
      errors++;
      $display("FAIL inflight_async: got rd_en=%b wr_en=%b vld=%b, want 0 0 0000", mmio_rd_en, mmio_wr_en, req_rd_valid);
    end
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (req_rd_valid !== 4'b0000) begin
        errors++;
        $display("FAIL inflight_discard c=%0d: got %b, want 0000", c, req_rd_valid);
      end
      next_cycle();
    end
  endtask

`ifdef MMIO_ARBITER_RANGE_CHECK_EN
  task automatic test_range();
    checks++;
    if (range_err !== 1'b0) begin
      errors++;
      $display("FAIL range_clear: got %b, want 0", range_err);
    end
    set_req(0, 1'b1, 1'b0, 16'h0080, '0);
    @(negedge clk);
    push_exp(0, '0);
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++;
    if (mmio_rd_en !== 1'b0 || range_err !== 1'b1) begin
      errors++;
      $display("FAIL range_reject: got rd_en=%b err=%b, want 0 1", mmio_rd_en, range_err);
    end
    next_cycle();
    set_req(0, 1'b1, 1'b0, 16'h0100, '0);
    @(negedge clk);
    ref_read(0, 16'h0100);
    next_cycle();
    set_req(0, 1'b0, 1'b1, 16'h0200, 64'h1);
    @(negedge clk);
    checks++;
    if (mmio_rd_en !== 1'b1 || mmio_rd_addr !== 16'h0100 || range_err !== 1'b1) begin
      errors++;
      $display("FAIL range_accept: got rd_en=%b addr=%h err=%b, want 1 0100 1", mmio_rd_en, mmio_rd_addr, range_err);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++;
    if (mmio_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL range_wr_reject: got wr_en=%b, want 0", mmio_wr_en);
    end
    next_cycle();
    next_cycle();
  endtask
`else
  task automatic test_range();
    checks++;
    if (range_err !== 1'b0) begin
      errors++;
      $display("FAIL range_tied: got %b, want 0", range_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_rd_wr();
    test_idle_priority();
    test_reset_inflight();
    test_range();
    next_cycle();
    next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
